// File: rtl/led_hit_scorer.sv
// Reaction-game scorer: credits hits, false presses and misses per LED lane,
// keeps a saturating score and miss count, and times a fixed-length game.
module led_hit_scorer #(
    parameter int N_LEDS      = 10,
    parameter int CLKS_PER_MS = 50000,
    parameter int GAME_MS     = 30000,
    parameter int SCORE_MAX   = 999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N_LEDS-1:0] led,
    input  logic [N_LEDS-1:0] btn,
    output logic              game_active,
    output logic              game_over,
    output logic [9:0]        score,
    output logic [9:0]        miss_count,
    output logic              hit_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int MW = (GAME_MS > 1) ? $clog2(GAME_MS + 1) : 1;
    localparam int CW = $clog2(N_LEDS + 1);
    localparam int SW = 13;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [MW-1:0] MS_LAST    = MW'(GAME_MS - 1);
    localparam logic signed [SW-1:0] SMAX = SW'(SCORE_MAX);

    state_t state;
    state_t state_next;

    logic [N_LEDS-1:0] btn_s1;
    logic [N_LEDS-1:0] btn_s2;
    logic [N_LEDS-1:0] btn_s3;
    logic [N_LEDS-1:0] led_q;
    logic [N_LEDS-1:0] credited;
    logic              start_q;

    logic [PW-1:0] presc;
    logic [MW-1:0] ms_cnt;

    logic [N_LEDS-1:0] btn_rise;
    logic [N_LEDS-1:0] hit_v;
    logic [N_LEDS-1:0] false_v;
    logic [N_LEDS-1:0] miss_v;
    logic [N_LEDS-1:0] credited_next;

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] f_cnt;
    logic [CW-1:0] m_cnt;

    logic signed [SW-1:0] score_sum;
    logic [9:0]           score_next;
    logic [10:0]          miss_sum;
    logic [9:0]           miss_next;

    logic start_rise;
    logic playing;
    logic go;
    logic ms_tick;
    logic game_end;

    assign btn_rise   = btn_s2 & ~btn_s3;
    assign start_rise = start & ~start_q;
    assign playing    = (state == PLAY);
    assign go         = start_rise & ~playing;
    assign ms_tick    = playing & (presc == PRESC_LAST);
    assign game_end   = ms_tick & (ms_cnt == MS_LAST);

    // Lane events are masked outside PLAY so IDLE/OVER ignore buttons and LEDs.
    assign hit_v   = {N_LEDS{playing}} & btn_rise & led & ~credited;
    assign false_v = {N_LEDS{playing}} & btn_rise & ~led;
    assign miss_v  = {N_LEDS{playing}} & led_q & ~led & ~credited;

    // A fresh hit wins over the LED-rise clear so repeat presses stay inert.
    assign credited_next = hit_v | (credited & ~(led ^ led_q));

    always_comb begin
        h_cnt = '0;
        f_cnt = '0;
        m_cnt = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            h_cnt = h_cnt + CW'(hit_v[i]);
            f_cnt = f_cnt + CW'(false_v[i]);
            m_cnt = m_cnt + CW'(miss_v[i]);
        end
    end

    always_comb begin
        score_sum = $signed({3'b000, score})
                  + $signed(SW'(h_cnt))
                  - $signed(SW'(f_cnt));
        score_next = score;
        if (score_sum[SW-1]) begin
            score_next = '0;
        end else if (score_sum > SMAX) begin
            score_next = SMAX[9:0];
        end else begin
            score_next = score_sum[9:0];
        end
    end

    always_comb begin
        miss_sum  = {1'b0, miss_count} + 11'(m_cnt);
        miss_next = miss_sum[10] ? 10'h3FF : miss_sum[9:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start_rise) state_next = PLAY;
            PLAY: if (game_end)   state_next = OVER;
            OVER: if (start_rise) state_next = PLAY;
            default:              state_next = IDLE;
        endcase
    end

    always_comb begin
        game_active = 1'b0;
        game_over   = 1'b0;
        unique case (state)
            PLAY:    game_active = 1'b1;
            OVER:    game_over   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1     <= '0;
            btn_s2     <= '0;
            btn_s3     <= '0;
            led_q      <= '0;
            start_q    <= 1'b0;
            credited   <= '0;
            presc      <= '0;
            ms_cnt     <= '0;
            score      <= '0;
            miss_count <= '0;
            hit_pulse  <= 1'b0;
        end else begin
            btn_s1    <= btn;
            btn_s2    <= btn_s1;
            btn_s3    <= btn_s2;
            led_q     <= led;
            start_q   <= start;
            hit_pulse <= 1'b0;
            if (go) begin
                credited   <= '0;
                presc      <= '0;
                ms_cnt     <= '0;
                score      <= '0;
                miss_count <= '0;
            end else if (playing) begin
                credited   <= credited_next;
                score      <= score_next;
                miss_count <= miss_next;
                hit_pulse  <= |hit_v;
                if (ms_tick) begin
                    presc  <= '0;
                    ms_cnt <= ms_cnt + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_hit_scorer.sv
// Directed bench for led_hit_scorer: a per-cycle vector table for the
// scoring rules plus hand-written timer, saturation and reset sequences.
module tb_led_hit_scorer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] led = '0;
    logic [9:0] btn = '0;
    logic       game_active;
    logic       game_over;
    logic [9:0] score;
    logic [9:0] miss_count;
    logic       hit_pulse;

    logic       start_t = 1'b0;
    logic [9:0] led_t = '0;
    logic [9:0] btn_t = '0;
    logic       active_t;
    logic       over_t;
    logic [9:0] score_t;
    logic [9:0] miss_t;
    logic       hit_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_hit_scorer #(
        .N_LEDS(10), .CLKS_PER_MS(2), .GAME_MS(2000), .SCORE_MAX(999)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .led(led), .btn(btn),
        .game_active(game_active), .game_over(game_over),
        .score(score), .miss_count(miss_count), .hit_pulse(hit_pulse)
    );

    led_hit_scorer #(
        .N_LEDS(10), .CLKS_PER_MS(4), .GAME_MS(3), .SCORE_MAX(999)
    ) dut_t (
        .clk(clk), .reset(reset), .start(start_t), .led(led_t), .btn(btn_t),
        .game_active(active_t), .game_over(over_t),
        .score(score_t), .miss_count(miss_t), .hit_pulse(hit_t)
    );

    typedef struct {
        logic [9:0] led;
        logic [9:0] btn;
        int         score;
        int         miss;
        logic       hit;
    } vec_t;

    vec_t tv[30];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic round(input logic [9:0] m);
        led = m;
        btn = m;
        tick();
        btn = '0;
        tick();
        tick();
        led = '0;
        tick();
    endtask

    initial begin
        int n;

        tv[0]  = '{10'h008, 10'h000, 0, 0, 1'b0};
        tv[1]  = '{10'h008, 10'h008, 0, 0, 1'b0};
        tv[2]  = '{10'h008, 10'h008, 0, 0, 1'b0};
        tv[3]  = '{10'h008, 10'h008, 1, 0, 1'b1};
        tv[4]  = '{10'h008, 10'h008, 1, 0, 1'b0};
        tv[5]  = '{10'h008, 10'h008, 1, 0, 1'b0};
        tv[6]  = '{10'h008, 10'h000, 1, 0, 1'b0};
        tv[7]  = '{10'h008, 10'h008, 1, 0, 1'b0};
        tv[8]  = '{10'h008, 10'h000, 1, 0, 1'b0};
        tv[9]  = '{10'h008, 10'h000, 1, 0, 1'b0};
        tv[10] = '{10'h000, 10'h000, 1, 0, 1'b0};
        tv[11] = '{10'h000, 10'h020, 1, 0, 1'b0};
        tv[12] = '{10'h000, 10'h000, 1, 0, 1'b0};
        tv[13] = '{10'h000, 10'h000, 0, 0, 1'b0};
        tv[14] = '{10'h000, 10'h020, 0, 0, 1'b0};
        tv[15] = '{10'h000, 10'h000, 0, 0, 1'b0};
        tv[16] = '{10'h000, 10'h000, 0, 0, 1'b0};
        tv[17] = '{10'h01F, 10'h01F, 0, 0, 1'b0};
        tv[18] = '{10'h01F, 10'h000, 0, 0, 1'b0};
        tv[19] = '{10'h01F, 10'h000, 5, 0, 1'b1};
        tv[20] = '{10'h000, 10'h000, 5, 0, 1'b0};
        tv[21] = '{10'h003, 10'h007, 5, 0, 1'b0};
        tv[22] = '{10'h003, 10'h000, 5, 0, 1'b0};
        tv[23] = '{10'h003, 10'h000, 6, 0, 1'b1};
        tv[24] = '{10'h000, 10'h000, 6, 0, 1'b0};
        tv[25] = '{10'h100, 10'h000, 6, 0, 1'b0};
        tv[26] = '{10'h100, 10'h100, 6, 0, 1'b0};
        tv[27] = '{10'h100, 10'h000, 6, 0, 1'b0};
        tv[28] = '{10'h000, 10'h000, 5, 1, 1'b0};
        tv[29] = '{10'h000, 10'h000, 5, 1, 1'b0};

        #1 reset = 1'b1;
        #2;
        chk("rst score", 32'(score), 0);
        chk("rst miss", 32'(miss_count), 0);
        chk("rst active", 32'(game_active), 0);
        chk("rst over", 32'(game_over), 0);
        chk("rst hit", 32'(hit_pulse), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // 4 clocks per ms, 3 ms game: 12 PLAY cycles.
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        n = 0;
        while (active_t && n < 50) begin
            n++;
            tick();
        end
        chk("timer play cycles", 32'(n), 12);
        chk("timer over", 32'(over_t), 1);
        chk("timer active low", 32'(active_t), 0);

        pulse_start();
        chk("start active", 32'(game_active), 1);
        chk("start score", 32'(score), 0);

        foreach (tv[i]) begin
            led = tv[i].led;
            btn = tv[i].btn;
            tick();
            chk($sformatf("row%0d score", i), 32'(score), 32'(tv[i].score));
            chk($sformatf("row%0d miss", i), 32'(miss_count), 32'(tv[i].miss));
            chk($sformatf("row%0d hit", i), 32'(hit_pulse), 32'(tv[i].hit));
        end

        led = 10'h020;
        btn = '0;
        for (int i = 0; i < 20; i++) tick();
        chk("lit no miss yet", 32'(miss_count), 1);
        led = '0;
        tick();
        chk("unpressed miss", 32'(miss_count), 2);
        chk("miss score kept", 32'(score), 5);

        for (int i = 0; i < 99; i++) round(10'h3FF);
        chk("rounds score", 32'(score), 995);
        round(10'h007);
        chk("pre-sat score", 32'(score), 998);

        led = 10'h038;
        btn = 10'h038;
        tick();
        btn = '0;
        tick();
        tick();
        chk("sat score", 32'(score), 999);
        chk("sat hit", 32'(hit_pulse), 1);
        led = '0;
        tick();
        chk("sat hit one cycle", 32'(hit_pulse), 0);
        chk("sat miss", 32'(miss_count), 2);

        n = 0;
        while (!game_over && n < 5000) begin
            n++;
            tick();
        end
        chk("main over", 32'(game_over), 1);
        chk("main active low", 32'(game_active), 0);

        round(10'h3FF);
        led = 10'h001;
        tick();
        led = '0;
        tick();
        chk("over score frozen", 32'(score), 999);
        chk("over miss frozen", 32'(miss_count), 2);
        chk("over no hit", 32'(hit_pulse), 0);

        pulse_start();
        chk("restart active", 32'(game_active), 1);
        chk("restart score", 32'(score), 0);
        chk("restart miss", 32'(miss_count), 0);

        round(10'h07F);
        chk("pre-reset score", 32'(score), 7);
        #2 reset = 1'b1;
        #1;
        chk("async rst score", 32'(score), 0);
        chk("async rst active", 32'(game_active), 0);
        chk("async rst miss", 32'(miss_count), 0);
        tick();
        tick();
        reset = 1'b0;
        round(10'h00F);
        chk("idle score", 32'(score), 0);
        chk("idle active", 32'(game_active), 0);
        chk("idle over", 32'(game_over), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
